// File: rtl/capture_pkg.sv
// Shared types and encodings for the trigger-based filter capture buffer.
package capture_pkg;

    typedef enum logic [2:0] {
        CAP_IDLE = 3'd0,
        CAP_PRE  = 3'd1,
        CAP_WAIT = 3'd2,
        CAP_POST = 3'd3,
        CAP_READ = 3'd4
    } cap_state_e;

    localparam int CAP_WIDTH = 32;

    // Packed so that a pair maps directly onto a rd_data word.
    typedef struct packed {
        logic [CAP_WIDTH-1:0] high_pass;
        logic [CAP_WIDTH-1:0] low_pass;
    } sample_pair_t;

    localparam logic SRC_LOW   = 1'b0;
    localparam logic SRC_HIGH  = 1'b1;
    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port record RAM: one write port, one synchronous read port.
module capture_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/filter_capture.sv
// Trigger capture of filter sample pairs with pre-trigger window and readout.
// Optional force_trig input when FILTER_CAPTURE_FORCE_TRIG_EN is defined.
module filter_capture
    import capture_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   low_pass,
    input  logic [WIDTH-1:0]   high_pass,
    input  logic               arm,
    input  logic               trig_src,
    input  logic               trig_edge,
    input  logic [WIDTH-1:0]   trig_level,
`ifdef FILTER_CAPTURE_FORCE_TRIG_EN
    input  logic               force_trig,
`endif
    output logic               armed,
    output logic               triggered,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [2*WIDTH-1:0] rd_data,
    output logic               rd_last
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   rcnt_t;

    localparam addr_t PRE_LAST  = addr_t'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
    localparam addr_t POST_INIT = addr_t'(DEPTH - PRE_TRIG - 1);
    localparam addr_t PRE_OFF   = addr_t'(PRE_TRIG);
    localparam rcnt_t RD_LAST   = rcnt_t'(DEPTH - 1);

    cap_state_e       state_q;
    addr_t            wr_ptr_q;
    addr_t            trig_ptr_q;
    addr_t            cnt_q;
    addr_t            rd_ptr_q;
    rcnt_t            rd_cnt_q;
    logic [WIDTH-1:0] prev_q;
    logic             prev_vld_q;
    logic             armed_q;
    logic             trig_q;
    logic             rd_valid_q;
    logic             rd_last_q;

    logic [WIDTH-1:0]   cur;
    logic               rise;
    logic               fall;
    logic               hit;
    logic               wr_en;
    logic               rd_en;
    logic [2*WIDTH-1:0] ram_rdata;

    assign cur  = (trig_src == SRC_HIGH) ? high_pass : low_pass;
    assign rise = ($signed(prev_q) <  $signed(trig_level))
               && ($signed(cur)    >= $signed(trig_level));
    assign fall = ($signed(prev_q) >  $signed(trig_level))
               && ($signed(cur)    <= $signed(trig_level));

`ifdef FILTER_CAPTURE_FORCE_TRIG_EN
    assign hit = force_trig
              || (prev_vld_q && ((trig_edge == EDGE_FALL) ? fall : rise));
`else
    assign hit = prev_vld_q && ((trig_edge == EDGE_FALL) ? fall : rise);
`endif

    // A POST count of zero means the record is already complete.
    assign wr_en = in_valid
                && ((state_q == CAP_PRE) || (state_q == CAP_WAIT)
                 || ((state_q == CAP_POST) && (cnt_q != '0)));

    // Fetch only when the output stage is empty or being drained.
    assign rd_en = (state_q == CAP_READ) && !rd_cnt_q[AW]
                && (!rd_valid_q || rd_ready);

    capture_ram #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({high_pass, low_pass}),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CAP_IDLE;
            wr_ptr_q   <= '0;
            trig_ptr_q <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            armed_q    <= 1'b0;
            trig_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                prev_q     <= cur;
                prev_vld_q <= 1'b1;
            end
            unique case (state_q)
                CAP_IDLE: begin
                    if (arm) begin
                        cnt_q      <= '0;
                        prev_vld_q <= 1'b0;
                        armed_q    <= 1'b1;
                        state_q    <= (PRE_TRIG == 0) ? CAP_WAIT : CAP_PRE;
                    end
                end
                CAP_PRE: begin
                    if (in_valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == PRE_LAST) begin
                            state_q <= CAP_WAIT;
                        end
                    end
                end
                CAP_WAIT: begin
                    if (in_valid && hit) begin
                        trig_ptr_q <= wr_ptr_q;
                        cnt_q      <= POST_INIT;
                        trig_q     <= 1'b1;
                        state_q    <= CAP_POST;
                    end
                end
                CAP_POST: begin
                    if (cnt_q == '0 || (in_valid && cnt_q == addr_t'(1))) begin
                        cnt_q    <= '0;
                        armed_q  <= 1'b0;
                        rd_ptr_q <= trig_ptr_q - PRE_OFF;
                        rd_cnt_q <= '0;
                        state_q  <= CAP_READ;
                    end else if (in_valid) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                CAP_READ: begin
                    if (rd_en) begin
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                        rd_cnt_q   <= rd_cnt_q + 1'b1;
                        rd_valid_q <= 1'b1;
                        rd_last_q  <= (rd_cnt_q == RD_LAST);
                    end else if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                    end
                    if (rd_valid_q && rd_ready && rd_last_q) begin
                        rd_last_q <= 1'b0;
                        trig_q    <= 1'b0;
                        state_q   <= CAP_IDLE;
                    end
                end
                default: begin
                    state_q <= CAP_IDLE;
                end
            endcase
        end
    end

    assign armed     = armed_q;
    assign triggered = trig_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_valid_q & rd_last_q;
    assign rd_data   = rd_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_filter_capture.sv
// Scenario-table and randomized bench for filter_capture (DEPTH=16, PRE_TRIG=4).
module tb_filter_capture;

    localparam int W   = 32;
    localparam int D   = 16;
    localparam int PRE = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  low_pass = '0;
    logic [W-1:0]  high_pass = '0;
    logic          arm = 1'b0;
    logic          trig_src = 1'b0;
    logic          trig_edge = 1'b0;
    logic [W-1:0]  trig_level = '0;
`ifdef FILTER_CAPTURE_FORCE_TRIG_EN
    logic          force_trig = 1'b0;
`endif
    logic          armed;
    logic          triggered;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [2*W-1:0] rd_data;
    logic          rd_last;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    filter_capture #(.WIDTH(W), .DEPTH(D), .PRE_TRIG(PRE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .low_pass   (low_pass),
        .high_pass  (high_pass),
        .arm        (arm),
        .trig_src   (trig_src),
        .trig_edge  (trig_edge),
        .trig_level (trig_level),
`ifdef FILTER_CAPTURE_FORCE_TRIG_EN
        .force_trig (force_trig),
`endif
        .armed      (armed),
        .triggered  (triggered),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last)
    );

    // mode: 0 ramp, 2 early crossing, 3 random, 4 forced trigger
    // rdy:  0 always ready, 1 toggling, 2 random
    typedef struct {
        int          mode;
        logic        src;
        logic        edg;
        logic [31:0] lvl;
        int          rdy;
        int          abort;
        logic        e4_en;
        logic [31:0] e4_lo;
        logic [31:0] e4_hi;
    } scen_t;

    scen_t tab[10];
    int    ntab;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run(input int idx, input scen_t s);
        logic [31:0] lo_q[$];
        logic [31:0] hi_q[$];
        int          neg_q[$];
        logic [63:0] got_q[$];
        logic [31:0] lo;
        logic [31:0] hi;
        int          n = 0;
        int          neg = 0;
        int          cyc = 0;
        int          first_trig = -1;
        int          fidx = -1;
        int          t = -1;
        logic        stall = 1'b0;
        logic        kill = 1'b0;
        logic [63:0] hold_d = '0;
        logic        hold_l = 1'b0;

        trig_src   = s.src;
        trig_edge  = s.edg;
        trig_level = s.lvl;
        @(negedge clk);
        arm = 1'b1;
        in_valid = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
        arm = 1'b0;
        chk($sformatf("s%0d armed", idx), 64'(armed), 64'd1);

        while (got_q.size() < D && cyc < 3000 && !kill) begin
            if (triggered && first_trig < 0) first_trig = neg;
            if (stall) begin
                chk($sformatf("s%0d stall_valid", idx), 64'(rd_valid), 64'd1);
                chk($sformatf("s%0d stall_data", idx), rd_data, hold_d);
                chk($sformatf("s%0d stall_last", idx), 64'(rd_last), 64'(hold_l));
            end
            in_valid = (s.mode == 3) ? ($urandom_range(0, 9) < 7) : 1'b1;
            case (s.mode)
                2: lo = (n == 1) ? 32'd15 : ((n < 8) ? 32'd0 : 32'(2 * n));
                3: lo = 32'($urandom_range(0, 100)) - 32'd50;
                4: lo = 32'(n + 30);
                default: lo = 32'(n);
            endcase
            hi = (s.mode == 3) ? 32'($urandom_range(0, 100)) - 32'd50
                               : 32'(100 - n);
            low_pass  = lo;
            high_pass = hi;
`ifdef FILTER_CAPTURE_FORCE_TRIG_EN
            force_trig = (s.mode == 4) && (lo == 32'd37);
            if (force_trig) fidx = n;
`endif
            if (in_valid) begin
                lo_q.push_back(lo);
                hi_q.push_back(hi);
                neg_q.push_back(neg);
                n++;
            end
            case (s.rdy)
                0: rd_ready = 1'b1;
                1: rd_ready = cyc[0];
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (rd_valid && rd_ready) begin
                got_q.push_back(rd_data);
                chk($sformatf("s%0d rd_last_w%0d", idx, got_q.size() - 1),
                    64'(rd_last), 64'(got_q.size() == D));
                if (got_q.size() == s.abort) kill = 1'b1;
            end
            stall  = rd_valid && !rd_ready;
            hold_d = rd_data;
            hold_l = rd_last;
            @(negedge clk);
            neg++;
            cyc++;
        end
        in_valid = 1'b0;
        rd_ready = 1'b0;
`ifdef FILTER_CAPTURE_FORCE_TRIG_EN
        force_trig = 1'b0;
`endif

        if (kill) begin
            rst = 1'b1;
            @(negedge clk);
            chk($sformatf("s%0d rst_valid", idx), 64'(rd_valid), 64'd0);
            chk($sformatf("s%0d rst_last", idx), 64'(rd_last), 64'd0);
            chk($sformatf("s%0d rst_data", idx), rd_data, 64'd0);
            chk($sformatf("s%0d rst_armed", idx), 64'(armed), 64'd0);
            chk($sformatf("s%0d rst_trig", idx), 64'(triggered), 64'd0);
            rst = 1'b0;
            return;
        end
        if (got_q.size() < D) begin
            chk($sformatf("s%0d readout_timeout", idx), 64'(got_q.size()), 64'(D));
            return;
        end

        // Reference: first valid pair past the pre-window that crosses.
        for (int i = PRE; i < lo_q.size(); i++) begin
            logic signed [31:0] pv;
            logic signed [31:0] cv;
            logic signed [31:0] lv;
            pv = s.src ? hi_q[i-1] : lo_q[i-1];
            cv = s.src ? hi_q[i]   : lo_q[i];
            lv = s.lvl;
            if (i == fidx || (!s.edg && pv < lv && cv >= lv)
                          || ( s.edg && pv > lv && cv <= lv)) begin
                t = i;
                break;
            end
        end
        if (t < 0 || t + (D - PRE - 1) >= lo_q.size()) begin
            chk($sformatf("s%0d model_trigger_found", idx), 64'(t), 64'(D));
            return;
        end
        chk($sformatf("s%0d trig_time", idx), 64'(first_trig), 64'(neg_q[t] + 1));
        for (int i = 0; i < D; i++) begin
            chk($sformatf("s%0d word%0d", idx, i), got_q[i],
                {hi_q[t - PRE + i], lo_q[t - PRE + i]});
        end
        if (s.e4_en) begin
            chk($sformatf("s%0d word4_const", idx), got_q[PRE], {s.e4_hi, s.e4_lo});
        end
        chk($sformatf("s%0d idle_trig", idx), 64'(triggered), 64'd0);
        chk($sformatf("s%0d idle_valid", idx), 64'(rd_valid), 64'd0);
        chk($sformatf("s%0d idle_armed", idx), 64'(armed), 64'd0);
    endtask

    initial begin
        //            mode src   edg   lvl     rdy abort e4  lo      hi
        tab[0] = '{0, 1'b0, 1'b0, 32'd10, 0, 0, 1'b1, 32'd10, 32'd90};
        tab[1] = '{0, 1'b1, 1'b1, 32'd50, 0, 0, 1'b1, 32'd50, 32'd50};
        tab[2] = '{2, 1'b0, 1'b0, 32'd10, 0, 0, 1'b1, 32'd16, 32'd92};
        tab[3] = '{0, 1'b0, 1'b0, 32'd10, 1, 0, 1'b1, 32'd10, 32'd90};
        tab[4] = '{0, 1'b0, 1'b0, 32'd10, 0, 5, 1'b0, 32'd0,  32'd0};
        tab[5] = '{0, 1'b0, 1'b0, 32'd10, 0, 0, 1'b1, 32'd10, 32'd90};
        ntab = 6;
        for (int i = 0; i < 3; i++) begin
            tab[ntab] = '{3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          32'd0, 2, 0, 1'b0, 32'd0, 32'd0};
            ntab++;
        end
`ifdef FILTER_CAPTURE_FORCE_TRIG_EN
        tab[ntab] = '{4, 1'b0, 1'b0, 32'd1000, 0, 0, 1'b1, 32'd37, 32'd93};
        ntab++;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_armed", 64'(armed), 64'd0);
        chk("reset_triggered", 64'(triggered), 64'd0);
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("reset_rd_last", 64'(rd_last), 64'd0);
        chk("reset_rd_data", rd_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < ntab; i++) begin
            run(i, tab[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/filter_capture.md
# filter_capture

Trigger-based capture buffer for the filter outputs: records `low_pass`/`high_pass` sample pairs into a circular RAM, fires on a programmable level crossing, keeps a configurable pre-trigger window, then streams the frozen record out over a valid/ready read port. It sits between `filter` and the oscilloscope display/readout logic. It is the consumer end of the filter's per-clock sample stream.

## Interface
- `WIDTH`, 32: bits per channel sample.
- `DEPTH`, 256: record length in sample pairs; power of 2, at least 4.
- `PRE_TRIG`, 64: samples kept before the trigger sample; 0 ≤ PRE_TRIG < DEPTH.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: a sample pair is present this cycle.
- `low_pass` in WIDTH: low-pass sample, signed two's complement.
- `high_pass` in WIDTH: high-pass sample, signed two's complement.
- `arm` in 1: single-cycle pulse that starts a capture; honoured only in IDLE.
- `trig_src` in 1: trigger channel; 0 = low_pass, 1 = high_pass.
- `trig_edge` in 1: 0 = rising, 1 = falling.
- `trig_level` in WIDTH: signed threshold.
- `armed` out 1: high in PRE, WAIT_TRIG and POST.
- `triggered` out 1: high in POST and READ.
- `rd_valid` out 1: `rd_data` holds a record word.
- `rd_ready` in 1: the consumer accepts a word.
- `rd_data` out 2·WIDTH: {high_pass, low_pass}, oldest pair first.
- `rd_last` out 1: marks the final (DEPTH-th) word, qualified by `rd_valid`.

## Operation
- FSM states: IDLE → PRE → WAIT_TRIG → POST → READ → IDLE.
- IDLE: no writes. `arm` clears the pre-count and the previous-sample-valid flag, then moves to PRE.
- PRE: every `in_valid` pair is written at `wr_ptr`, and `wr_ptr` increments mod DEPTH. After PRE_TRIG pairs the FSM moves to WAIT_TRIG. With PRE_TRIG = 0 the FSM goes straight to WAIT_TRIG.
- WAIT_TRIG: writing continues; the ring overwrites the oldest data.
  - Rising trigger: prev < trig_level and cur ≥ trig_level.
  - Falling trigger: prev > trig_level and cur ≤ trig_level.
  - All comparisons are signed WIDTH-bit.
  - The first pair after `arm` never triggers, because it has no prev. PRE samples do update prev, but a crossing inside PRE is ignored.
- Trigger pair: it is written, and `trig_ptr` = its address. The FSM moves to POST with `post_cnt` = DEPTH−PRE_TRIG−1.
- POST: each written pair decrements `post_cnt`. When the count reaches 0, or on entry when it is already 0, the FSM moves to READ and writing stops.
- READ: rd_ptr starts at (trig_ptr − PRE_TRIG) mod DEPTH and emits DEPTH words. The trigger pair is word index PRE_TRIG. After the `rd_last` handshake the FSM returns to IDLE.
- `in_valid` is ignored outside PRE, WAIT_TRIG and POST. `arm` is ignored outside IDLE.
- Trigger configuration inputs are sampled every cycle; software holds them stable while `armed`.
- `rst` at any time, including mid-READ: state = IDLE and all outputs drop to 0. RAM contents are don't-care.

## Timing
- Reset values: `armed`=0, `triggered`=0, `rd_valid`=0, `rd_last`=0, `rd_data`=0.
- `arm` at edge N → `armed`=1 from N+1.
- Trigger pair accepted at edge N → `triggered`=1 from N+1.
- The RAM read is synchronous with 1-cycle latency. The first `rd_valid` rises at most 2 cycles after entering READ.
- The read port is a skid/prefetch stage sustaining 1 word/cycle while `rd_ready`=1.
- `rd_data` and `rd_last` stay stable while `rd_valid`=1 and `rd_ready`=0.
- `rd_valid` never drops without a handshake.

## Configuration
- `FILTER_CAPTURE_FORCE_TRIG_EN` defined: adds input `force_trig` (1 bit).
  - In WAIT_TRIG, `force_trig`=1 with `in_valid` makes that pair the trigger, regardless of level.
  - In PRE, `force_trig` is ignored.
- Macro undefined: the port is absent and triggering is level-crossing only.

## Structure
- `capture_pkg` holds:
  - the state enum (`CAP_IDLE`, `CAP_PRE`, `CAP_WAIT`, `CAP_POST`, `CAP_READ`);
  - typedef `sample_pair_t` as a packed {high_pass, low_pass};
  - the trig_src/trig_edge encoding constants.
- Sub-module `capture_ram`: simple dual-port RAM, one write port and one synchronous read port, parameterised by WIDTH and DEPTH.

## Test plan
All scenarios use DEPTH=16, PRE_TRIG=4 and `in_valid` held at 1.
- Ramp: low_pass = 0,1,2,…; arm; trig_level=10, rising, src 0 → readout is 6…21, the trigger value 10 is at index 4, and `rd_last` is on 21.
- Falling trigger: high_pass = 100 − n, level 50 → word 4 = 50, 16 words, both channels correct.
- Early crossing: the crossing occurs in the 2nd pair, inside PRE → no trigger; `triggered` stays 0 until a later crossing.
- Backpressure: `rd_ready` toggles every other cycle during READ → exactly 16 handshakes, in order, with data stable during stalls.
- Reset: `rst` after 5 words read → next cycle `rd_valid`=0, IDLE. A re-arm captures correctly.
- Macro defined: level never crossed, `force_trig` pulsed in WAIT_TRIG on value 37 → word 4 = 37.
